// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shared RAM port arbiter for per-core icache/dcache requesters
// Dcache beats icache, round-robin within each class, grant locked for a whole burst.
module mem_arbiter #(
  parameter int CPUS = 2
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [CPUS-1:0]        iREN,
  input  logic [CPUS-1:0][31:0]  iaddr,
  input  logic [CPUS-1:0]        dREN,
  input  logic [CPUS-1:0]        dWEN,
  input  logic [CPUS-1:0][31:0]  daddr,
  input  logic [CPUS-1:0][31:0]  dstore,
  output logic [CPUS-1:0]        iwait,
  output logic [CPUS-1:0]        dwait,
  output logic [CPUS-1:0][31:0]  iload,
  output logic [CPUS-1:0][31:0]  dload,
  output logic                   ramREN,
  output logic                   ramWEN,
  output logic [31:0]            ramaddr,
  output logic [31:0]            ramstore,
  input  logic [31:0]            ramload,
  input  logic                   ram_ready
);

  localparam int IW = (CPUS > 1) ? $clog2(CPUS) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state_q, state_d;
  logic            gnt_is_d_q, gnt_is_d_d;
  logic [IW-1:0]   gnt_idx_q, gnt_idx_d;
  logic [IW-1:0]   d_last_q, d_last_d;
  logic [IW-1:0]   i_last_q, i_last_d;

  logic [CPUS-1:0] d_act, i_act;
  logic            d_found, i_found;
  logic [IW-1:0]   d_win, i_win;
  logic            gnt_act;

  // Returns {found, index}: first active core strictly after last, wrapping modulo CPUS.
  function automatic logic [IW:0] rr_pick(input logic [CPUS-1:0] act, input logic [IW-1:0] last);
    logic [IW:0]   r;
    logic [IW-1:0] ci;
    r = '0;
    for (int k = CPUS; k >= 1; k--) begin
      ci = IW'((int'(last) + k) % CPUS);
      if (act[ci]) r = {1'b1, ci};
    end
    return r;
  endfunction

  assign d_act = dREN | dWEN;
  assign i_act = iREN;
  assign {d_found, d_win} = rr_pick(d_act, d_last_q);
  assign {i_found, i_win} = rr_pick(i_act, i_last_q);
  assign gnt_act = gnt_is_d_q ? d_act[gnt_idx_q] : i_act[gnt_idx_q];

  assign iload = {CPUS{ramload}};
  assign dload = {CPUS{ramload}};

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      gnt_is_d_q <= 1'b0;
      gnt_idx_q  <= '0;
      d_last_q   <= IW'(CPUS - 1);
      i_last_q   <= IW'(CPUS - 1);
    end else begin
      state_q    <= state_d;
      gnt_is_d_q <= gnt_is_d_d;
      gnt_idx_q  <= gnt_idx_d;
      d_last_q   <= d_last_d;
      i_last_q   <= i_last_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    gnt_is_d_d = gnt_is_d_q;
    gnt_idx_d  = gnt_idx_q;
    d_last_d   = d_last_q;
    i_last_d   = i_last_q;
    case (state_q)
      IDLE: begin
        if (d_found) begin
          state_d    = BUSY;
          gnt_is_d_d = 1'b1;
          gnt_idx_d  = d_win;
          d_last_d   = d_win;
        end else if (i_found) begin
          state_d    = BUSY;
          gnt_is_d_d = 1'b0;
          gnt_idx_d  = i_win;
          i_last_d   = i_win;
        end
      end
      BUSY: begin
        // Grant is held until the owner drops its request, even across REN/WEN switches.
        if (!gnt_act) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = '1;
    dwait    = '1;
    if (state_q == BUSY && !RST) begin
      if (gnt_is_d_q) begin
        dwait[gnt_idx_q] = ~ram_ready;
        if (gnt_act) begin
          ramWEN   = dWEN[gnt_idx_q];
          ramREN   = dREN[gnt_idx_q] & ~dWEN[gnt_idx_q];
          ramaddr  = daddr[gnt_idx_q];
          ramstore = dstore[gnt_idx_q];
        end
      end else begin
        iwait[gnt_idx_q] = ~ram_ready;
        if (gnt_act) begin
          ramREN  = 1'b1;
          ramaddr = iaddr[gnt_idx_q];
        end
      end
    end
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single RAM port between the instruction and data caches of `CPUS` processor cores. It sits between the caches' cache-control signals (REN/WEN/addr/store/load/wait) and the RAM. Grants go to one requester at a time, with dcache priority over icache and round-robin fairness within each class. A grant is held across a requester's multi-word burst (dcache wb1→wb2→fetch1→fetch2, or fetch1→fetch2), so that burst is never interleaved with another requester.

## Interface
- `CPUS`, 2, number of cores; each core has one icache requester and one dcache requester, for 2·CPUS requesters in total.
- `CLK`  in  1  clock; all state updates on rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `iREN`  in  CPUS  icache read request, per core.
- `iaddr`  in  CPUS×32  icache word address, per core.
- `dREN`  in  CPUS  dcache read request, per core.
- `dWEN`  in  CPUS  dcache write request, per core.
- `daddr`  in  CPUS×32  dcache word address, per core.
- `dstore`  in  CPUS×32  dcache write data, per core.
- `iwait`  out  CPUS  1 = icache access not complete this cycle.
- `dwait`  out  CPUS  1 = dcache access not complete this cycle.
- `iload`  out  CPUS×32  read data, = `ramload` for every core; valid only when the matching wait is 0.
- `dload`  out  CPUS×32  read data, = `ramload` for every core; valid only when the matching wait is 0.
- `ramREN`  out  1  RAM read enable.
- `ramWEN`  out  1  RAM write enable.
- `ramaddr`  out  32  RAM address.
- `ramstore`  out  32  RAM write data.
- `ramload`  in  32  RAM read data.
- `ram_ready`  in  1  RAM completes the presented access this cycle.

## Operation
- Registered state:
  - FSM state, `IDLE` or `BUSY`.
  - Grant: class (I/D) plus core index.
  - Round-robin pointers `d_last` and `i_last`, each log2(CPUS) bits, holding the last-granted core per class.
- A requester is active when:
  - dcache: `dREN[c] | dWEN[c]`.
  - icache: `iREN[c]`.
- Arbitration happens only in `IDLE`, when any requester is active:
  - If any dcache requester is active, grant the first active dcache core searching upward from `d_last+1`, modulo CPUS.
  - Otherwise, grant the first active icache core searching upward from `i_last+1`.
  - Update only the winning class's pointer to the winner.
  - Go to `BUSY`.
- `IDLE` with no active requester stays in `IDLE`.
- `BUSY`:
  - Route the granted requester to RAM:
    - dcache: `ramWEN=dWEN[g]`, `ramREN=dREN[g]&~dWEN[g]`, `ramaddr=daddr[g]`, `ramstore=dstore[g]`.
    - icache: `ramREN=1`, `ramWEN=0`, `ramaddr=iaddr[g]`.
  - The granted requester's wait = `~ram_ready`.
  - If the granted requester is no longer active, drive RAM enables 0 and go to `IDLE` next cycle.
  - Otherwise stay in `BUSY`, including across consecutive words and a REN↔WEN switch (the lock).
- When `dREN` and `dWEN` are both high, the write wins and the read is not issued.
- All non-granted requesters have wait=1 at all times; `IDLE` drives wait=1 for everyone.
- In `IDLE`: `ramREN=ramWEN=0`, and `ramaddr` and `ramstore` are 0.
- Reset (`RST`=1 at an edge, including mid-burst):
  - State `IDLE`, grant cleared, `d_last=i_last=CPUS-1`, so core 0 wins first.
  - The in-flight access is abandoned; the RAM sees enables 0 from the next cycle.
  - All waits are 1 and RAM enables are 0 while in reset.

## Timing
- Grant latency:
  - Request first high in cycle N while in `IDLE` → RAM enables asserted in cycle N+1.
  - Earliest wait=0 is in cycle N+1, if `ram_ready`=1.
  - Minimum single-word latency: 2 cycles.
- Burst: each further word completes on any cycle where `ram_ready`=1, with no gap between words.
- Release:
  - The request drops in cycle M → cycle M is `BUSY` with enables 0.
  - Cycle M+1 is `IDLE` and arbitrates.
  - A competing requester's access starts at M+2.
- A requester must hold address, data and enables stable while its wait=1.
- Wait and RAM outputs are combinational from the registered grant and state plus current inputs; there is no combinational path from request inputs to the grant.
- Starvation bound: a lower-priority icache request waits while any dcache requester is active in `IDLE`. Within a class, at most CPUS-1 bursts precede a given core.

## Test plan
- **Single dcache read:** reset, then core0 `dREN`=1 with `daddr`=0x40 and `ram_ready` tied 1 → `ramREN`=1, `ramaddr`=0x40 in cycle 2; `dwait[0]`=0 in cycle 2; `dload[0]`=`ramload`.
- **Priority:** `iREN[0]` and `dREN[1]` rise in the same cycle → `dcache[1]` is granted. `iwait[0]` stays 1 until `dREN[1]` drops, then icache0 is served 2 cycles later.
- **Burst lock:**
  - Stimulus: core0 dcache runs a write 0x48/0xAAAA then 0x4C/0xBBBB, then reads 0x80 and 0x84 back-to-back with `ram_ready` pulsing every 3rd cycle, while core1 `dREN` is held high.
  - Required: all 4 core0 accesses reach RAM in order with no core1 access between them, and core1 is granted only after core0 idles.
- **Round-robin:** both dcache requesters continuously re-request single words with `ram_ready`=1 → grants alternate 0,1,0,1; `d_last` toggles each grant.
- **Simultaneous REN+WEN:** `dREN[0]`=`dWEN[0]`=1 with `dstore`=0x1234 → `ramWEN`=1, `ramREN`=0, `ramstore`=0x1234.
- **Reset mid-burst:** assert `RST` one cycle during core0's second burst word with `ram_ready`=0 → next cycle `ramREN`=`ramWEN`=0 and all waits are 1. After `RST` falls, core0 (still requesting) is re-granted first.
